// File: rtl/decode_stage_hz.sv
// Decode stage with register file, WB write-through bypass, load-use
// hazard FSM and the ID/EX pipeline register.
//
// Control word produced by rv32i_decoder (26 bits):
//   [25:21] rd        [20:16] rs2       [15:11] rs1      [10:8] funct3
//   [7] reg_write     [6] mem_read      [5] mem_write    [4] branch
//   [3] B operand is immediate          [2] jump         [1] instr[30]
//   [0] legal instruction
// A bubble or an illegal opcode produces an all-zero word, so unused
// register fields read as x0 and can never raise a hazard.

module rv32i_decoder (
    input  logic [31:0] instr,
    input  logic        bubble,
    output logic [25:0] control,
    output logic [2:0]  branch_sel
);
    logic [6:0] opcode_s;
    logic       legal_s;
    logic       use_rs1_s;
    logic       use_rs2_s;
    logic       reg_write_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       branch_s;
    logic       b_imm_s;
    logic       jump_s;

    assign opcode_s = instr[6:0];

    // Classify the opcode into the operands and features it uses
    always_comb begin
        legal_s     = 1'b1;
        use_rs1_s   = 1'b0;
        use_rs2_s   = 1'b0;
        reg_write_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        branch_s    = 1'b0;
        b_imm_s     = 1'b0;
        jump_s      = 1'b0;
        case (opcode_s)
            7'b0110011: begin // OP: funct7 must be 0000000 or 0100000
                legal_s     = (instr[31] == 1'b0) && (instr[29:25] == 5'd0);
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
                reg_write_s = 1'b1;
            end
            7'b0010011: begin // OP-IMM
                use_rs1_s = 1'b1; reg_write_s = 1'b1; b_imm_s = 1'b1;
            end
            7'b0000011: begin // LOAD
                use_rs1_s = 1'b1; reg_write_s = 1'b1; mem_read_s = 1'b1; b_imm_s = 1'b1;
            end
            7'b0100011: begin // STORE
                use_rs1_s = 1'b1; use_rs2_s = 1'b1; mem_write_s = 1'b1; b_imm_s = 1'b1;
            end
            7'b1100011: begin // BRANCH
                use_rs1_s = 1'b1; use_rs2_s = 1'b1; branch_s = 1'b1;
            end
            7'b1100111: begin // JALR
                use_rs1_s = 1'b1; reg_write_s = 1'b1; jump_s = 1'b1; b_imm_s = 1'b1;
            end
            7'b1101111: begin // JAL
                reg_write_s = 1'b1; jump_s = 1'b1; b_imm_s = 1'b1;
            end
            7'b0110111, 7'b0010111: begin // LUI, AUIPC
                reg_write_s = 1'b1; b_imm_s = 1'b1;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Assemble the control word and branch select; bubble/illegal gives zeros
    always_comb begin
        control    = 26'd0;
        branch_sel = 3'd0;
        if (!bubble && legal_s) begin
            control[25:21] = reg_write_s ? instr[11:7]  : 5'd0;
            control[20:16] = use_rs2_s   ? instr[24:20] : 5'd0;
            control[15:11] = use_rs1_s   ? instr[19:15] : 5'd0;
            control[10:8]  = instr[14:12];
            control[7]     = reg_write_s;
            control[6]     = mem_read_s;
            control[5]     = mem_write_s;
            control[4]     = branch_s;
            control[3]     = b_imm_s;
            control[2]     = jump_s;
            control[1]     = instr[30];
            control[0]     = 1'b1;
            // branch: funct3; JAL: 010; JALR: 011 (only meaningful with [4]/[2])
            if (branch_s) begin
                branch_sel = instr[14:12];
            end else if (jump_s) begin
                branch_sel = use_rs1_s ? 3'b011 : 3'b010;
            end else begin
                branch_sel = 3'b000;
            end
        end else begin
            control    = 26'd0;
            branch_sel = 3'd0;
        end
    end
endmodule

module decode_stage_hz #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int CTRL_W    = 26,
    parameter int LOAD_LAT  = 1,
    parameter int BYPASS_EN = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_plus_i,
    input  logic              bp_i,
    input  logic              buble,
    input  logic              flush,
    input  logic              hold_i,
    input  logic              ex_is_load_i,
    input  logic [AW-1:0]     ex_rd_i,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              stall_o,
    output logic [AW-1:0]     rs1_addr,
    output logic [AW-1:0]     rs2_addr,
    output logic              valid_o,
    output logic [XLEN-1:0]   data_a_o,
    output logic [XLEN-1:0]   data_b_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [XLEN-1:0]   pc_plus_o,
    output logic [CTRL_W-1:0] control_signal_o,
    output logic [2:0]        branch_sel_o,
    output logic              bp_o,
    output logic [15:0]       stall_cnt_o
);
    typedef enum logic [0:0] {RUN = 1'b0, LU_STALL = 1'b1} state_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   data_a;
        logic [XLEN-1:0]   data_b;
        logic [XLEN-1:0]   store_data;
        logic [XLEN-1:0]   pc_plus;
        logic [CTRL_W-1:0] ctrl;
        logic [2:0]        branch_sel;
        logic              bp;
    } idex_t;

    localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

    logic [25:0]     dec_ctrl_s;
    logic [2:0]      dec_bsel_s;
    logic [AW-1:0]   rs1_s;
    logic [AW-1:0]   rs2_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic [XLEN-1:0] rf_r [NREGS];
    logic            hazard_s;
    logic            stall_s;
    state_t          state_r;
    state_t          state_n;
    logic [1:0]      cnt_r;
    logic [1:0]      cnt_n;
    idex_t           idex_r;
    idex_t           idex_cap_s;
    logic [15:0]     stall_cnt_r;

    rv32i_decoder u_dec (
        .instr      (instr_i),
        .bubble     (buble),
        .control    (dec_ctrl_s),
        .branch_sel (dec_bsel_s)
    );

    assign rs1_s    = AW'(dec_ctrl_s[15:11]);
    assign rs2_s    = AW'(dec_ctrl_s[20:16]);
    assign rs1_addr = rs1_s;
    assign rs2_addr = rs2_s;

    // Register file storage: x0 is never written and is cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wb_we_i && (wb_rd_i != '0)) begin
            rf_r[wb_rd_i] <= wb_data_i;
        end
    end

    // Operand reads: x0 is hard zero, WB data written through when enabled
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
        if (rs1_s == '0) begin
            rd1_s = '0;
        end else if ((BYPASS_EN != 0) && wb_we_i && (wb_rd_i == rs1_s)) begin
            rd1_s = wb_data_i;
        end else begin
            rd1_s = rf_r[rs1_s];
        end
        if (rs2_s == '0) begin
            rd2_s = '0;
        end else if ((BYPASS_EN != 0) && wb_we_i && (wb_rd_i == rs2_s)) begin
            rd2_s = wb_data_i;
        end else begin
            rd2_s = rf_r[rs2_s];
        end
    end

    assign hazard_s = !buble && ex_is_load_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == rs1_s) || (ex_rd_i == rs2_s));

    // Load-use FSM next state. The detecting RUN cycle is the first stall
    // cycle; cnt holds the LU_STALL cycles still owed, so the FSM returns to
    // RUN once the count is used up, giving LOAD_LAT stall cycles in total.
    // A flush or hold cycle never stalls: flush discards IF/ID, hold freezes.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        stall_s = 1'b0;
        if (flush) begin
            state_n = RUN;
            cnt_n   = 2'd0;
        end else if (hold_i) begin
            state_n = state_r;
            cnt_n   = cnt_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (hazard_s) begin
                        stall_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_n = LU_STALL;
                            cnt_n   = LAT_M1;
                        end else begin
                            state_n = RUN;
                            cnt_n   = 2'd0;
                        end
                    end else begin
                        state_n = RUN;
                        cnt_n   = cnt_r;
                    end
                end
                LU_STALL: begin
                    stall_s = 1'b1;
                    if (cnt_r <= 2'd1) begin
                        state_n = RUN;
                        cnt_n   = 2'd0;
                    end else begin
                        state_n = LU_STALL;
                        cnt_n   = cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = 2'd0;
                end
            endcase
        end
    end

    assign stall_o = stall_s;

    // Load-use FSM state and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Values captured into ID/EX on a normal cycle
    always_comb begin
        idex_cap_s            = '0;
        idex_cap_s.valid      = 1'b1;
        idex_cap_s.data_a     = rd1_s;
        idex_cap_s.data_b     = dec_ctrl_s[3] ? imm_i : rd2_s;
        idex_cap_s.store_data = rd2_s;
        idex_cap_s.pc_plus    = pc_plus_i;
        idex_cap_s.ctrl       = CTRL_W'(dec_ctrl_s);
        idex_cap_s.branch_sel = dec_bsel_s;
        idex_cap_s.bp         = bp_i;
    end

    // ID/EX register: flush clears, hold freezes, stall/bubble inserts a nop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_r <= '0;
        end else if (flush) begin
            idex_r <= '0;
        end else if (hold_i) begin
            idex_r <= idex_r;
        end else if (stall_s || buble) begin
            idex_r <= '0;
        end else begin
            idex_r <= idex_cap_s;
        end
    end

    // Saturating count of stall cycles (a statistic, kept across flushes)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 16'd0;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign valid_o          = idex_r.valid;
    assign data_a_o         = idex_r.data_a;
    assign data_b_o         = idex_r.data_b;
    assign store_data_o     = idex_r.store_data;
    assign pc_plus_o        = idex_r.pc_plus;
    assign control_signal_o = idex_r.ctrl;
    assign branch_sel_o     = idex_r.branch_sel;
    assign bp_o             = idex_r.bp;
    assign stall_cnt_o      = stall_cnt_r;
endmodule
